// File: rtl/prbs16_checker_if.sv
// Bit-stream and status bundle between the PRBS receive path and prbs16_checker.
// The master side supplies received bits; the slave side is the checker itself.
interface prbs16_checker_if #(
    parameter int ERR_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             clear_counts;
    logic             locked;
    logic             bit_error;
    logic [ERR_W-1:0] err_count;

    modport master (
        output bit_in, bit_valid, clear_counts,
        input  locked, bit_error, err_count
    );

    modport slave (
        input  bit_in, bit_valid, clear_counts,
        output locked, bit_error, err_count
    );
endinterface

// File: rtl/prbs16_checker.sv
// Self-synchronising checker for the 16-bit XNOR LFSR stream (taps 15/14/12/3).
// Hunts for 16 bits, verifies a run of predictions, then tracks errors and loss of lock.
module prbs16_checker #(
    parameter int LOCK_BITS   = 32,
    parameter int LOSS_WINDOW = 64,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    prbs16_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_e;

    localparam logic [7:0] LOCK_CNT = 8'(LOCK_BITS);
    localparam logic [7:0] WIN_LAST = 8'(LOSS_WINDOW - 1);
    localparam logic [7:0] THRESH   = 8'(LOSS_THRESH);

    state_e           state_q, state_d;
    logic [15:0]      shiftReg_q, shiftReg_d;
    logic [3:0]       fillCnt_q, fillCnt_d;
    logic [7:0]       matchCnt_q, matchCnt_d;
    logic [7:0]       winCnt_q, winCnt_d;
    logic [7:0]       winErr_q, winErr_d;
    logic             bitError_q, bitError_d;
    logic [ERR_W-1:0] errCount_q, errCount_d;

    logic             expBit;
    logic             matchBit;
    logic [7:0]       matchNext;
    logic [7:0]       winErrNext;
    logic [15:0]      shiftedIn;

    assign expBit     = ~(shiftReg_q[15] ^ shiftReg_q[14] ^ shiftReg_q[12] ^ shiftReg_q[3]);
    assign matchBit   = (bus.bit_in == expBit);
    assign matchNext  = matchCnt_q + 8'd1;
    assign winErrNext = winErr_q + {7'd0, ~matchBit};
    assign shiftedIn  = {shiftReg_q[14:0], bus.bit_in};

    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        fillCnt_d  = fillCnt_q;
        matchCnt_d = matchCnt_q;
        winCnt_d   = winCnt_q;
        winErr_d   = winErr_q;
        bitError_d = 1'b0;
        errCount_d = errCount_q;

        if (bus.bit_valid) begin
            unique case (state_q)
                HUNT: begin
                    shiftReg_d = shiftedIn;
                    fillCnt_d  = fillCnt_q + 4'd1;
                    if (fillCnt_q == 4'd15) begin
                        state_d    = VERIFY;
                        matchCnt_d = 8'd0;
                    end
                end
                VERIFY: begin
                    shiftReg_d = shiftedIn;
                    if (!matchBit) begin
                        matchCnt_d = 8'd0;
                    end else if (matchNext == LOCK_CNT) begin
                        matchCnt_d = 8'd0;
                        // An all-ones register predicts all ones forever: the XNOR lock-up state.
                        if (shiftedIn == 16'hFFFF) begin
                            state_d   = HUNT;
                            fillCnt_d = 4'd0;
                        end else begin
                            state_d  = LOCKED;
                            winCnt_d = 8'd0;
                            winErr_d = 8'd0;
                        end
                    end else begin
                        matchCnt_d = matchNext;
                    end
                end
                LOCKED: begin
                    // Feed back the prediction so received errors never poison the register.
                    shiftReg_d = {shiftReg_q[14:0], expBit};
                    if (!matchBit) begin
                        bitError_d = 1'b1;
                        if (errCount_q != {ERR_W{1'b1}}) begin
                            errCount_d = errCount_q + {{(ERR_W-1){1'b0}}, 1'b1};
                        end
                    end
                    if (winErrNext == THRESH) begin
                        state_d   = HUNT;
                        fillCnt_d = 4'd0;
                    end else if (winCnt_q == WIN_LAST) begin
                        winCnt_d = 8'd0;
                        winErr_d = 8'd0;
                    end else begin
                        winCnt_d = winCnt_q + 8'd1;
                        winErr_d = winErrNext;
                    end
                end
                default: begin
                    state_d   = HUNT;
                    fillCnt_d = 4'd0;
                end
            endcase
        end

        if (bus.clear_counts) begin
            errCount_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            shiftReg_q <= 16'd0;
            fillCnt_q  <= 4'd0;
            matchCnt_q <= 8'd0;
            winCnt_q   <= 8'd0;
            winErr_q   <= 8'd0;
            bitError_q <= 1'b0;
            errCount_q <= '0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            fillCnt_q  <= fillCnt_d;
            matchCnt_q <= matchCnt_d;
            winCnt_q   <= winCnt_d;
            winErr_q   <= winErr_d;
            bitError_q <= bitError_d;
            errCount_q <= errCount_d;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.bit_error = bitError_q;
    assign bus.err_count = errCount_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Bench for prbs16_checker: a stream-level model checked every cycle, plus literal pins.
// A second, narrow-counter instance exercises err_count saturation within a short run.
module tb_prbs16_checker;

    localparam int LOCK_BITS   = 32;
    localparam int LOSS_WINDOW = 64;
    localparam int LOSS_THRESH = 8;
    localparam int ERR_W       = 16;
    localparam int SAT_W       = 4;
    localparam int MAX_MAIN    = (1 << ERR_W) - 1;
    localparam int MAX_SAT     = (1 << SAT_W) - 1;

    logic clk = 1'b0;
    logic resetIn = 1'b1;
    logic bitIn = 1'b0;
    logic bitValid = 1'b0;
    logic clearCounts = 1'b0;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    logic [15:0] genState;

    prbs16_checker_if #(.ERR_W(ERR_W)) busMain ();
    prbs16_checker_if #(.ERR_W(SAT_W)) busSat ();

    assign busMain.bit_in       = bitIn;
    assign busMain.bit_valid    = bitValid;
    assign busMain.clear_counts = clearCounts;
    assign busSat.bit_in        = bitIn;
    assign busSat.bit_valid     = bitValid;
    assign busSat.clear_counts  = 1'b0;

    prbs16_checker #(
        .LOCK_BITS(LOCK_BITS), .LOSS_WINDOW(LOSS_WINDOW),
        .LOSS_THRESH(LOSS_THRESH), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset(resetIn), .bus(busMain)
    );

    prbs16_checker #(
        .LOCK_BITS(LOCK_BITS), .LOSS_WINDOW(LOSS_WINDOW),
        .LOSS_THRESH(LOSS_THRESH), .ERR_W(SAT_W)
    ) dutSat (
        .clk(clk), .reset(resetIn), .bus(busSat)
    );

    always #5 clk = ~clk;

    // Stream-level model: history of the last 16 effective bits, phase and run counters.
    int   mPhase = 0;
    int   mFill = 0;
    int   mRun = 0;
    int   mWinBits = 0;
    int   mWinErrs = 0;
    int   mErr = 0;
    int   mErrSat = 0;
    logic mLocked = 1'b0;
    logic mBitErr = 1'b0;
    bit   hist[$];

    always @(posedge clk) begin
        bit pred;
        bit allOnes;
        if (resetIn) begin
            mPhase = 0; mFill = 0; mRun = 0; mWinBits = 0; mWinErrs = 0;
            mErr = 0; mErrSat = 0; mBitErr = 1'b0;
            hist.delete();
            for (int k = 0; k < 16; k++) hist.push_back(1'b0);
        end else begin
            mBitErr = 1'b0;
            if (bitValid) begin
                pred = ~(hist[0] ^ hist[1] ^ hist[3] ^ hist[12]);
                if (mPhase == 0) begin
                    hist.push_back(bitIn); hist.delete(0);
                    mFill++;
                    if (mFill == 16) begin mPhase = 1; mRun = 0; end
                end else if (mPhase == 1) begin
                    hist.push_back(bitIn); hist.delete(0);
                    mRun = (bitIn == pred) ? mRun + 1 : 0;
                    if (mRun == LOCK_BITS) begin
                        mRun = 0;
                        allOnes = 1'b1;
                        foreach (hist[k]) if (!hist[k]) allOnes = 1'b0;
                        if (allOnes) begin
                            mPhase = 0; mFill = 0;
                        end else begin
                            mPhase = 2; mWinBits = 0; mWinErrs = 0;
                        end
                    end
                end else begin
                    hist.push_back(pred); hist.delete(0);
                    mWinBits++;
                    if (bitIn != pred) begin
                        mBitErr = 1'b1;
                        mWinErrs++;
                        if (mErr < MAX_MAIN) mErr++;
                        if (mErrSat < MAX_SAT) mErrSat++;
                    end
                    if (mWinErrs == LOSS_THRESH) begin
                        mPhase = 0; mFill = 0;
                    end else if (mWinBits == LOSS_WINDOW) begin
                        mWinBits = 0; mWinErrs = 0;
                    end
                end
            end
            if (clearCounts) mErr = 0;
        end
        mLocked = (mPhase == 2);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model locked",       32'(busMain.locked),    32'(mLocked));
            checkOutput("model bit_error",    32'(busMain.bit_error), 32'(mBitErr));
            checkOutput("model err_count",    32'(busMain.err_count), mErr);
            checkOutput("model sat locked",   32'(busSat.locked),     32'(mLocked));
            checkOutput("model sat err_count", 32'(busSat.err_count), mErrSat);
        end
    end

    task automatic applyStimulus(input logic v, input logic b, input logic clr);
        @(negedge clk);
        bitValid    = v;
        bitIn       = b;
        clearCounts = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic genBit(output logic b);
        b = ~(genState[15] ^ genState[14] ^ genState[12] ^ genState[3]);
        genState = {genState[14:0], b};
    endtask

    task automatic sendClean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            genBit(b);
            applyStimulus(1'b1, b, 1'b0);
        end
    endtask

    task automatic sendErr(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            genBit(b);
            applyStimulus(1'b1, ~b, 1'b0);
        end
    endtask

    initial begin
        logic       b;
        logic [4:0] first5;

        resetIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'(i), 1'($urandom), 1'b0);
            checkEn = 1'b1;
        end
        checkOutput("reset locked",    32'(busMain.locked),    32'd0);
        checkOutput("reset bit_error", 32'(busMain.bit_error), 32'd0);
        checkOutput("reset err_count", 32'(busMain.err_count), 32'd0);
        resetIn = 1'b0;

        // Acquisition from a generator seeded with zero.
        genState = 16'd0;
        for (int i = 0; i < 5; i++) begin
            genBit(b);
            first5[4-i] = b;
            applyStimulus(1'b1, b, 1'b0);
        end
        checkOutput("gen first bits", 32'(first5), 32'h1E);
        sendClean(42);
        checkOutput("acquire bit47 locked", 32'(busMain.locked), 32'd0);
        sendClean(1);
        checkOutput("acquire bit48 locked", 32'(busMain.locked), 32'd1);
        checkOutput("acquire err_count",    32'(busMain.err_count), 32'd0);

        // Single error, then clear and align to the next window boundary.
        sendClean(20);
        sendErr(1);
        checkOutput("single bit_error", 32'(busMain.bit_error), 32'd1);
        checkOutput("single err_count", 32'(busMain.err_count), 32'd1);
        checkOutput("single locked",    32'(busMain.locked),    32'd1);
        sendClean(1);
        checkOutput("single pulse end", 32'(busMain.bit_error), 32'd0);
        sendClean(30);
        genBit(b);
        applyStimulus(1'b1, b, 1'b1);
        checkOutput("clear err_count", 32'(busMain.err_count), 32'd0);
        sendClean(11);

        // Loss of lock on the 8th error of a fresh window, then relock.
        sendErr(7);
        checkOutput("loss 7 locked",    32'(busMain.locked),    32'd1);
        checkOutput("loss 7 err_count", 32'(busMain.err_count), 32'd7);
        sendErr(1);
        checkOutput("loss 8 locked",    32'(busMain.locked),    32'd0);
        checkOutput("loss 8 err_count", 32'(busMain.err_count), 32'd8);
        checkOutput("loss 8 bit_error", 32'(busMain.bit_error), 32'd1);
        sendClean(47);
        checkOutput("relock 47 locked", 32'(busMain.locked), 32'd0);
        sendClean(1);
        checkOutput("relock 48 locked", 32'(busMain.locked), 32'd1);

        // Second loss drives the narrow counter into saturation.
        sendErr(8);
        checkOutput("loss2 locked",     32'(busMain.locked),    32'd0);
        checkOutput("loss2 err_count",  32'(busMain.err_count), 32'd16);
        checkOutput("loss2 sat count",  32'(busSat.err_count),  32'hF);
        sendClean(48);
        checkOutput("relock2 locked",   32'(busMain.locked),    32'd1);
        sendErr(1);
        checkOutput("sat hold count",   32'(busSat.err_count),  32'hF);
        checkOutput("sat main count",   32'(busMain.err_count), 32'd17);
        checkOutput("sat bit_error",    32'(busSat.bit_error),  32'd1);

        // Error coincident with clear_counts.
        genBit(b);
        applyStimulus(1'b1, ~b, 1'b1);
        checkOutput("clear+err bit_error", 32'(busMain.bit_error), 32'd1);
        checkOutput("clear+err err_count", 32'(busMain.err_count), 32'd0);

        // Reset pulse while locked, then reacquire from hunt.
        resetIn = 1'b1;
        genBit(b);
        applyStimulus(1'b1, b, 1'b0);
        resetIn = 1'b0;
        checkOutput("midreset locked",    32'(busMain.locked),    32'd0);
        checkOutput("midreset bit_error", 32'(busMain.bit_error), 32'd0);
        checkOutput("midreset err_count", 32'(busMain.err_count), 32'd0);
        checkOutput("midreset sat count", 32'(busSat.err_count),  32'd0);
        sendClean(47);
        checkOutput("reacq 47 locked", 32'(busMain.locked), 32'd0);
        sendClean(1);
        checkOutput("reacq 48 locked", 32'(busMain.locked), 32'd1);

        // Constant-one stream is the lock-up pattern and must never lock.
        resetIn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        resetIn = 1'b0;
        for (int i = 0; i < 200; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("ones locked", 32'(busMain.locked), 32'd0);

        // Clean stream with bit_valid at a 1-in-3 duty.
        resetIn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        resetIn = 1'b0;
        genState = 16'd0;
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'b0, 1'($urandom), 1'b0);
            applyStimulus(1'b0, 1'($urandom), 1'b0);
            genBit(b);
            applyStimulus(1'b1, b, 1'b0);
            if (i == 46) checkOutput("gapped 47 locked", 32'(busMain.locked), 32'd0);
        end
        checkOutput("gapped 48 locked",  32'(busMain.locked),    32'd1);
        checkOutput("gapped err_count",  32'(busMain.err_count), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0);
        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs16_checker.md
# prbs16_checker

Serial PRBS checker for the 16-bit LFSR random-number stream. It self-synchronises to a bit stream produced by the 16-bit generator, which uses XNOR taps 15/14/12/3 and shifts left, with the output bit being the new LSB. Once synchronised it flags and counts bit errors and declares loss of lock when errors become too dense. It sits on the receive/loopback side of the PRNG and drives lock/error indication to the display logic.

## Interface
- LOCK_BITS, 32: consecutive correct predictions required before LOCKED (1..255).
- LOSS_WINDOW, 64: valid-bit window length for loss-of-lock evaluation (2..255).
- LOSS_THRESH, 8: errors within one window that force loss of lock (1..LOSS_WINDOW).
- ERR_W, 16: width of err_count.
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  received stream bit.
- bit_valid  in  1  bit_in is sampled on cycles where this is high; it may be high every cycle.
- clear_counts  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- bit_error  out  1  one-cycle pulse per mismatched bit while LOCKED.
- err_count  out  ERR_W  saturating count of LOCKED-state errors.

## Operation
- Shift register s[15:0]. Prediction: exp = ~(s[15]^s[14]^s[12]^s[3]). Every shift is s <= {s[14:0], b}.
- States are HUNT, VERIFY and LOCKED. Reset puts the block in HUNT with s=0, fill_cnt=0, match_cnt=0, win_cnt=0, win_err=0, locked=0, bit_error=0, err_count=0.
- HUNT: each valid bit shifts bit_in into s and increments fill_cnt. On the 16th valid bit: go to VERIFY, match_cnt=0.
- VERIFY: each valid bit shifts bit_in into s.
  - Match (bit_in==exp): match_cnt++.
  - Mismatch: match_cnt=0 and stay in VERIFY. No refill is needed because s already holds the last 16 received bits.
  - When match_cnt reaches LOCK_BITS: if the post-shift s==16'hFFFF (XNOR lock-up stream), go to HUNT with fill_cnt=0. Otherwise go to LOCKED with win_cnt=0, win_err=0.
  - bit_error is never asserted in HUNT or VERIFY.
- LOCKED: each valid bit shifts exp (not bit_in) into s, so received errors do not corrupt the prediction.
  - Mismatch: bit_error pulse, err_count++ (saturates at all-ones), win_err++.
  - win_cnt counts valid bits 0..LOSS_WINDOW-1. On the bit that completes the window, win_cnt and win_err restart from 0, with that bit's error counted before the test.
  - If win_err (including the current bit) reaches LOSS_THRESH: go to HUNT with fill_cnt=0. Loss takes priority over the window restart.
- clear_counts sets err_count=0 and wins over a simultaneous increment. The bit_error pulse still occurs. State and window counters are unaffected.
- bit_valid=0 freezes s, all counters and the state. bit_error is 0 on such cycles.
- reset asserted in any state (including mid-window in LOCKED) returns every register to its reset value on the next edge.

## Timing
- All outputs are registered.
- bit_error is high exactly in the cycle after the edge that samples the erroneous bit.
- err_count updates on that same edge.
- locked rises on the edge sampling the LOCK_BITS-th consecutive match. From reset, with a clean stream, that is edge number 16+LOCK_BITS of valid bits.
- locked falls on the edge sampling the LOSS_THRESH-th in-window error.
- Minimum relock after loss: 16+LOCK_BITS valid bits.
- Throughput: one bit per clock.

## Test plan
- Reset values: hold reset 3 cycles with bit_valid toggling -> locked=0, bit_error=0, err_count=0, and no output changes.
- Acquire: feed a reference generator stream seeded s=0 (first bits 1,1,1,1,0,...), bit_valid every cycle -> locked rises after valid bit 48, bit_error never pulses, err_count=0.
- Single error: after lock, invert one bit -> exactly one bit_error pulse in the following cycle, err_count=1, locked stays 1, subsequent clean bits give no errors.
- Loss of lock: invert 8 bits within one 64-bit window -> locked falls on the 8th error, err_count=8. Then the clean stream continues -> locked rises again 48 valid bits later.
- Degenerate and gapped streams: constant-1 stream for 200 bits -> locked never rises. Clean stream with bit_valid at a 1-in-3 duty -> lock after 48 valid bits, counters unaffected by idle cycles.
- Simultaneous events: error bit coincident with clear_counts -> err_count=0 and bit_error pulses. Err_count at 16'hFFFF plus one more error -> stays 16'hFFFF. Reset pulse mid-LOCKED -> all outputs 0 next cycle and reacquisition from HUNT.
